// File: rtl/loop_ring_monitor_if.sv
// Signal bundle for loop_ring_monitor: ring controls and monitor results.
// The master drives ring controls; the slave (the monitor) returns ring state and results.
interface loop_ring_monitor_if #(
    parameter int unsigned STAGES = 9,
    parameter int unsigned WIN    = 16
);
    localparam int unsigned CNT_W = $clog2(WIN + 1);

    logic              en;
    logic [STAGES-1:0] pin;
    logic              load;
    logic              seed;
    logic              start;
    logic              loop_q;
    logic [STAGES-1:0] taps;
    logic              busy;
    logic              done;
    logic              osc;
    logic              stable;
    logic [CNT_W-1:0]  toggles;

    modport master (
        output en, pin, load, seed, start,
        input  loop_q, taps, busy, done, osc, stable, toggles
    );

    modport slave (
        input  en, pin, load, seed, start,
        output loop_q, taps, busy, done, osc, stable, toggles
    );
endinterface

// File: rtl/loop_ring_monitor.sv
// Registered AND/NAND gate ring closed through one flop, plus a windowed toggle monitor
// that classifies the ring as oscillating, stable or settling.
module loop_ring_monitor #(
    parameter int unsigned        STAGES    = 9,
    parameter logic [STAGES-1:0]  NAND_MASK = 9'b0_0001_0000,
    parameter int unsigned        WIN       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    loop_ring_monitor_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIN + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    if (STAGES < 2) begin : g_bad_stages
        $error("loop_ring_monitor: STAGES must be at least 2");
    end
    if (WIN < 2) begin : g_bad_win
        $error("loop_ring_monitor: WIN must be at least 2");
    end

    state_e            state_q, state_d;
    logic              ring_q, ring_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  toggles_q, toggles_d;
    logic              osc_q, osc_d;
    logic              stable_q, stable_d;
    logic [CNT_W-1:0]  cnt_next;
    logic              toggle;
    logic              stage [STAGES];
    logic [STAGES-1:0] taps;

    // Unpacked per-stage nets keep the chain free of self-referencing vector bits.
    assign stage[0] = NAND_MASK[0] ? ~(ring_q & bus.pin[0]) : (ring_q & bus.pin[0]);

    for (genvar i = 1; i < STAGES; i++) begin : g_stage
        assign stage[i] = NAND_MASK[i] ? ~(stage[i-1] & bus.pin[i])
                                       :  (stage[i-1] & bus.pin[i]);
    end

    always_comb begin
        taps = '0;
        for (int i = 0; i < STAGES; i++) begin
            taps[i] = stage[i];
        end
    end

    always_comb begin
        ring_d = ring_q;
        if (bus.load) begin
            ring_d = bus.seed;
        end else if (bus.en) begin
            ring_d = stage[STAGES-1];
        end
    end

    assign toggle   = ring_d ^ ring_q;
    assign cnt_next = cnt_q + CNT_W'(toggle);

    // DONE also accepts start so a new window can begin the edge right after done.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        toggles_d = toggles_q;
        osc_d     = osc_q;
        stable_d  = stable_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    win_d   = '0;
                end
            end
            StRun: begin
                cnt_d = cnt_next;
                win_d = win_q + 1'b1;
                if (win_q == CNT_W'(WIN - 1)) begin
                    state_d   = StDone;
                    toggles_d = cnt_next;
                    osc_d     = (cnt_next >= CNT_W'(2));
                    stable_d  = (cnt_next == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ring_q    <= 1'b0;
            cnt_q     <= '0;
            win_q     <= '0;
            toggles_q <= '0;
            osc_q     <= 1'b0;
            stable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ring_q    <= ring_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            toggles_q <= toggles_d;
            osc_q     <= osc_d;
            stable_q  <= stable_d;
        end
    end

    assign bus.loop_q  = ring_q;
    assign bus.taps    = taps;
    assign bus.busy    = (state_q == StRun);
    assign bus.done    = (state_q == StDone);
    assign bus.osc     = osc_q;
    assign bus.stable  = stable_q;
    assign bus.toggles = toggles_q;

    a_done_single : assert property (@(posedge clk) disable iff (!rst_n)
        bus.done |=> !bus.done);
    a_busy_done_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.busy && bus.done));
endmodule

// File: tb/tb_loop_ring_monitor.sv
// Bench for loop_ring_monitor: directed windows with literal results, then random traffic
// compared every cycle against an edge-indexed window model.
module tb_loop_ring_monitor;
    localparam int unsigned STAGES = 9;
    localparam int unsigned WIN    = 16;
    localparam int unsigned CNT_W  = $clog2(WIN + 1);
    localparam logic [STAGES-1:0] NAND_MASK = 9'b0_0001_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    loop_ring_monitor_if #(.STAGES(STAGES), .WIN(WIN)) bus ();

    loop_ring_monitor #(
        .STAGES   (STAGES),
        .NAND_MASK(NAND_MASK),
        .WIN      (WIN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [STAGES-1:0] ring(input logic lq, input logic [STAGES-1:0] p);
        logic v;
        logic [STAGES-1:0] r;
        v = lq;
        for (int i = 0; i < STAGES; i++) begin
            v = v & p[i];
            if (NAND_MASK[i]) v = ~v;
            r[i] = v;
        end
        return r;
    endfunction

    // Model: windows tracked by the index of the edge that accepted start.
    logic            m_loop = 1'b0;
    logic            m_active = 1'b0;
    logic            m_done = 1'b0;
    logic            m_osc = 1'b0;
    logic            m_stable = 1'b0;
    int              m_tog = 0;
    int              m_cnt = 0;
    int              m_k = 0;
    int              m_edge = 0;
    logic            m_nxt;
    logic [STAGES-1:0] m_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loop = 1'b0; m_active = 1'b0; m_done = 1'b0;
            m_osc = 1'b0; m_stable = 1'b0; m_tog = 0; m_cnt = 0;
        end else begin
            m_r   = ring(m_loop, bus.pin);
            m_nxt = bus.load ? bus.seed : (bus.en ? m_r[STAGES-1] : m_loop);
            if (m_active && m_edge > m_k && m_nxt != m_loop) m_cnt++;
            m_loop = m_nxt;
            m_done = m_active && (m_edge == m_k + int'(WIN));
            if (m_done) begin
                m_tog = m_cnt; m_osc = (m_cnt >= 2); m_stable = (m_cnt == 0);
                m_active = 1'b0;
            end else if (!m_active && bus.start) begin
                m_k = m_edge; m_cnt = 0; m_active = 1'b1;
            end
            m_edge++;
        end
    end

    always @(negedge clk) begin
        check("loop_q",  32'(bus.loop_q),  32'(m_loop));
        check("taps",    32'(bus.taps),    32'(ring(m_loop, bus.pin)));
        check("busy",    32'(bus.busy),    32'(m_active));
        check("done",    32'(bus.done),    32'(m_done));
        check("osc",     32'(bus.osc),     32'(m_osc));
        check("stable",  32'(bus.stable),  32'(m_stable));
        check("toggles", 32'(bus.toggles), 32'(m_tog));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads seed together with start, then runs a fixed span; optional mid-window load
    // and start re-pulses. Checks done timing, count and literal results.
    task automatic window(input string name, input logic [STAGES-1:0] p, input logic s,
                          input logic e, input int mid_n, input logic mid_seed,
                          input logic repulse, input int exp_tog, input logic exp_osc,
                          input logic exp_stable);
        int ndone = 0;
        int done_at = -1;
        int tog_at = -1;
        logic osc_at = 1'b0;
        logic stable_at = 1'b0;
        bus.pin = p; bus.seed = s; bus.en = e; bus.load = 1'b1; bus.start = 1'b1;
        step();
        bus.load = 1'b0; bus.start = 1'b0;
        for (int n = 1; n <= int'(WIN) + 4; n++) begin
            step();
            if (bus.done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = n; tog_at = int'(bus.toggles);
                    osc_at = bus.osc; stable_at = bus.stable;
                end
            end
            bus.load  = (n == mid_n);
            bus.seed  = (n == mid_n) ? mid_seed : s;
            bus.start = repulse && (n == 3 || n == 10);
        end
        bus.load = 1'b0; bus.start = 1'b0;
        check({name, ".latency"}, 32'(done_at), 32'(WIN));
        check({name, ".ndone"},   32'(ndone),   32'd1);
        check({name, ".toggles"}, 32'(tog_at),  32'(exp_tog));
        check({name, ".osc"},     32'(osc_at),  32'(exp_osc));
        check({name, ".stable"},  32'(stable_at), 32'(exp_stable));
    endtask

    initial begin
        bus.en = 1'b0; bus.pin = '1; bus.load = 1'b0; bus.seed = 1'b0; bus.start = 1'b0;
        repeat (2) step();
        check("reset.loop_q", 32'(bus.loop_q), 32'd0);
        check("reset.taps",   32'(bus.taps),   32'h1F0);
        check("reset.busy",   32'(bus.busy),   32'd0);
        check("reset.toggles", 32'(bus.toggles), 32'd0);
        rst_n = 1'b1;
        step();

        window("osc",      9'h1FF, 1'b1, 1'b1, 0, 1'b0, 1'b0, 16, 1'b1, 1'b0);
        window("pin4",     9'h1EF, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0,  1'b0, 1'b1);
        window("settle",   9'h1FE, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1,  1'b0, 1'b0);
        window("en_off",   9'h1FF, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0,  1'b0, 1'b1);

        // Abort mid-window with an asynchronous reset.
        bus.pin = 9'h1FF; bus.seed = 1'b1; bus.en = 1'b1; bus.load = 1'b1; bus.start = 1'b1;
        step();
        bus.load = 1'b0; bus.start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("abort.busy",    32'(bus.busy),    32'd0);
        check("abort.done",    32'(bus.done),    32'd0);
        check("abort.stable",  32'(bus.stable),  32'd0);
        check("abort.toggles", 32'(bus.toggles), 32'd0);
        check("abort.loop_q",  32'(bus.loop_q),  32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        window("after_rst", 9'h1FF, 1'b1, 1'b1, 0, 1'b0, 1'b0, 16, 1'b1, 1'b0);
        window("repulse",   9'h1FF, 1'b1, 1'b1, 0, 1'b0, 1'b1, 16, 1'b1, 1'b0);
        window("mid_load",  9'h1EF, 1'b1, 1'b0, 6, 1'b0, 1'b0, 1,  1'b0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            bus.pin   = ($urandom_range(0, 3) == 0) ? STAGES'($urandom) : '1;
            bus.en    = ($urandom_range(0, 3) != 0);
            bus.load  = ($urandom_range(0, 15) == 0);
            bus.seed  = 1'($urandom);
            bus.start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        bus.start = 1'b0;
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
